t_min_sec: RTL and testbench
============================

// Module: t_min_sec
// PURPOSE
//  Timebase and minute/second counter for the digital clock. Divides clk50 to a
//  1 Hz tick, counts seconds 0..59 and minutes 0..59, and drives the hour-carry
//  interface (equal60, disable_hour) consumed by the hour counter. Supports
//  push-button minute adjust and seconds clear, and drives four 7-segment digits.
// PARAMETERS
//  CLK_HZ     50_000_000  clk50 cycles per 1 Hz tick (sim: small, e.g. 10)
//  PULSE_LEN  4           clk50 cycles equal60 is held high per carry (>=1)
// PORTS
//  clk50        in   1  system clock, 50 MHz
//  reset        in   1  asynchronous, active-low reset
//  run          in   1  1 = timebase advances; 0 = prescaler and counters frozen
//  control0     in   1  adjust direction: 1 = up, 0 = down
//  control1     in   1  adjust button, active-low (0 = pressed)
//  adj_sel      in   1  0 = button adjusts minutes; 1 = button clears seconds
//  equal60      out  1  hour-carry pulse: minute wrapped 59->0 by natural count
//  disable_hour out  1  1 = hour counter must ignore equal60
//  sec          out  6  seconds, binary 0..59
//  min          out  6  minutes, binary 0..59
//  tick_1hz     out  1  one-cycle strobe when the prescaler expires (run=1)
//  led_s1/led_s2 out 7  seconds ones/tens digit, 7-seg active-low segments
//  led_m1/led_m2 out 7  minutes ones/tens digit, 7-seg active-low segments
// BEHAVIOUR
//  Reset (reset=0, async): prescaler=0, sec=0, min=0, equal60=0, disable_hour=0,
//   tick_1hz=0, press-armed flag=1 (ready). Digits show 00:00 after reset.
//  Prescaler: counts 0..CLK_HZ-1 while run=1; tick_1hz=1 on the cycle it equals
//   CLK_HZ-1, then it returns to 0. run=0 holds the count, tick_1hz=0.
//  Seconds: on tick, sec+1; 59 -> 0 and generates a minute carry in the same cycle.
//  Minutes: on minute carry, min+1; 59 -> 0 starts an equal60 pulse.
//  equal60: registered; rises 1 cycle after the 59:59->00:00 tick, stays high
//   exactly PULSE_LEN cycles, then low. Never asserted by manual adjust.
//  Button: edge-detected, one action per press. Action fires on first cycle with
//   control1=0 and armed=1; armed clears; armed re-sets on the first cycle
//   control1=1. Holding the button never repeats the action.
//   adj_sel=0: min+1 (59->0) if control0=1, else min-1 (0->59). No equal60.
//   adj_sel=1: sec=0 and prescaler=0 (synchronises seconds); min unchanged.
//  disable_hour = ~control1 (registered): hour counter ignores carries while the
//   button is held.
//  Simultaneous events: button action on minutes has priority over a tick carry
//   in the same cycle (carry dropped, no equal60); seconds still advance on that
//   tick. Seconds clear has priority over a tick (sec=0, not 1).
//  equal60 pulse in progress when button pressed: pulse completes unchanged.
//  Reset mid-pulse: equal60 drops immediately (async), pulse counter cleared.
//  Width rules: sec/min never exceed 59; any value >59 (defensive) wraps to 0.
//  Display: sec/min split into tens/ones (0..5, 0..9) and decoded combinationally.
// STRUCTURE
//  Shared package/header: SEC_MAX=59, MIN_MAX=59, 7-seg digit code table.
//  Sub-modules: reuse the team's separate (binary->tens/ones) and led7_decoder
//   blocks, one per digit; one natural new sub-module: t_prescaler (CLK_HZ
//   divider with run gate and sync clear).
// TESTING (CLK_HZ=10, PULSE_LEN=4)
//  1. Release reset, run=1, 600 ticks -> sec/min wrap; at 59:59 tick, min=0, sec=0,
//     equal60 high exactly 4 cycles starting 1 cycle later; tick_1hz every 10 cycles.
//  2. adj_sel=0, control0=1, press at min=59 -> min=0, equal60 stays 0, disable_hour=1
//     while held; hold 50 cycles -> only one increment.
//  3. adj_sel=0, control0=0, press at min=0 -> min=59; release/press again -> 58.
//  4. Press (adj_sel=0, up) on the same cycle as the 59:59 tick -> min=0 via
//     button, sec=0, no equal60 pulse.
//  5. adj_sel=1, press at sec=37 mid-second -> sec=0, prescaler=0; next tick
//     exactly 10 cycles later; run=0 freezes sec/min/prescaler, tick_1hz=0.
//  6. Assert reset during an equal60 pulse -> equal60=0, sec=min=0 immediately;
//     digits decode to 00:00.

Source files
------------

// File: rtl/t_min_sec_pkg.sv
// Shared constants and digit helpers for the minute/second counter.
// Binary-to-tens/ones split and 7-segment lookup live here so every digit uses the same table.
package t_min_sec_pkg;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Split a 0..59 binary value into tens/ones; out-of-range inputs show as 5x.
  function automatic bcd2_t split_bcd(input logic [5:0] v);
    bcd2_t      r;
    logic [5:0] base;
    if (v >= 6'd50) begin
      r.tens = 4'd5;
      base   = 6'd50;
    end else if (v >= 6'd40) begin
      r.tens = 4'd4;
      base   = 6'd40;
    end else if (v >= 6'd30) begin
      r.tens = 4'd3;
      base   = 6'd30;
    end else if (v >= 6'd20) begin
      r.tens = 4'd2;
      base   = 6'd20;
    end else if (v >= 6'd10) begin
      r.tens = 4'd1;
      base   = 6'd10;
    end else begin
      r.tens = 4'd0;
      base   = 6'd0;
    end
    r.ones = 4'(v - base);
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/t_min_sec_if.sv
// Control/status bundle between the minute/second counter and its user.
// The master drives run and the buttons; the slave (counter) drives time, carry and digits.
interface t_min_sec_if;
  logic       run;
  logic       control0;
  logic       control1;
  logic       adj_sel;
  logic       equal60;
  logic       disable_hour;
  logic [5:0] sec;
  logic [5:0] min;
  logic       tick_1hz;
  logic [6:0] led_s1;
  logic [6:0] led_s2;
  logic [6:0] led_m1;
  logic [6:0] led_m2;

  modport master (
    output run, control0, control1, adj_sel,
    input  equal60, disable_hour, sec, min, tick_1hz, led_s1, led_s2, led_m1, led_m2
  );

  modport slave (
    input  run, control0, control1, adj_sel,
    output equal60, disable_hour, sec, min, tick_1hz, led_s1, led_s2, led_m1, led_m2
  );
endinterface

// File: rtl/t_min_sec_prescaler.sv
// CLK_HZ divider producing a one-cycle tick; run freezes the count, clr_i restarts the second.
module t_min_sec_prescaler #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] CntMax = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = (cnt_q >= CntMax) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/t_min_sec.sv
// Minute/second counter with 1 Hz timebase, hour-carry pulse, button adjust and 7-seg digits.
module t_min_sec
  import t_min_sec_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned PULSE_LEN = 4
) (
  input  logic         clk50,
  input  logic         reset,
  t_min_sec_if.slave   bus
);

  localparam int unsigned PW = $clog2(PULSE_LEN + 1);

  logic          tick;
  logic          armed_q;
  logic          fire, sec_clr, min_adj, carry, wrap_start;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic          equal60_q, equal60_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          dis_hour_q;
  bcd2_t         s_bcd, m_bcd;

  t_min_sec_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .clk_i  (clk50),
    .rst_ni (reset),
    .run_i  (bus.run),
    .clr_i  (sec_clr),
    .tick_o (tick)
  );

  // armed_q is simply "button was released last cycle": one action per press.
  assign fire    = ~bus.control1 & armed_q;
  assign sec_clr = fire & bus.adj_sel;
  assign min_adj = fire & ~bus.adj_sel;

  always_comb begin
    sec_d = sec_q;
    carry = 1'b0;
    if (sec_clr) begin
      sec_d = '0;
    end else if (tick) begin
      if (sec_q >= SEC_MAX) begin
        sec_d = '0;
        carry = (sec_q == SEC_MAX);
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // A manual minute adjust swallows any carry from the same tick.
  always_comb begin
    min_d      = min_q;
    wrap_start = 1'b0;
    if (min_adj) begin
      if (bus.control0) begin
        min_d = (min_q >= MIN_MAX) ? '0 : min_q + 6'd1;
      end else if (min_q == '0) begin
        min_d = MIN_MAX;
      end else begin
        min_d = (min_q > MIN_MAX) ? '0 : min_q - 6'd1;
      end
    end else if (carry) begin
      if (min_q >= MIN_MAX) begin
        min_d      = '0;
        wrap_start = (min_q == MIN_MAX);
      end else begin
        min_d = min_q + 6'd1;
      end
    end
  end

  always_comb begin
    equal60_d = equal60_q;
    pcnt_d    = pcnt_q;
    if (equal60_q) begin
      if (pcnt_q == '0) begin
        equal60_d = 1'b0;
      end else begin
        pcnt_d = pcnt_q - PW'(1);
      end
    end else if (wrap_start) begin
      equal60_d = 1'b1;
      pcnt_d    = PW'(PULSE_LEN - 1);
    end
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      sec_q      <= '0;
      min_q      <= '0;
      equal60_q  <= 1'b0;
      pcnt_q     <= '0;
      armed_q    <= 1'b1;
      dis_hour_q <= 1'b0;
    end else begin
      sec_q      <= sec_d;
      min_q      <= min_d;
      equal60_q  <= equal60_d;
      pcnt_q     <= pcnt_d;
      armed_q    <= bus.control1;
      dis_hour_q <= ~bus.control1;
    end
  end

  assign s_bcd = split_bcd(sec_q);
  assign m_bcd = split_bcd(min_q);

  assign bus.sec          = sec_q;
  assign bus.min          = min_q;
  assign bus.equal60      = equal60_q;
  assign bus.disable_hour = dis_hour_q;
  assign bus.tick_1hz     = tick;
  assign bus.led_s1       = seg7(s_bcd.ones);
  assign bus.led_s2       = seg7(s_bcd.tens);
  assign bus.led_m1       = seg7(m_bcd.ones);
  assign bus.led_m2       = seg7(m_bcd.tens);

endmodule

// File: tb/tb_t_min_sec.sv
// Directed bench for t_min_sec with a 10-cycle second and 4-cycle hour-carry pulse.
module tb_t_min_sec;

  logic clk50 = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   n;
  int   cnt;

  t_min_sec_if bus ();

  t_min_sec #(
    .CLK_HZ    (10),
    .PULSE_LEN (4)
  ) dut (
    .clk50 (clk50),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk50 = ~clk50;

  task automatic cyc(input int k);
    repeat (k) @(negedge clk50);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Negedges until tick_1hz is seen, bounded at 40.
  task automatic wait_tick(output int k);
    k = 0;
    while (bus.tick_1hz !== 1'b1 && k < 40) begin
      cyc(1);
      k++;
    end
  endtask

  task automatic press(input logic up);
    bus.adj_sel  = 1'b0;
    bus.control0 = up;
    bus.control1 = 1'b0;
    cyc(1);
    bus.control1 = 1'b1;
    cyc(1);
  endtask

  task automatic sync_clear();
    bus.adj_sel  = 1'b1;
    bus.control1 = 1'b0;
    cyc(1);
    bus.control1 = 1'b1;
    bus.adj_sel  = 1'b0;
  endtask

  initial begin
    bus.run = 1'b0; bus.control0 = 1'b1; bus.control1 = 1'b1; bus.adj_sel = 1'b0;
    cyc(3);
    check("rst_sec", 32'(bus.sec), 32'd0);
    check("rst_min", 32'(bus.min), 32'd0);
    check("rst_eq60", 32'(bus.equal60), 32'd0);
    check("rst_dish", 32'(bus.disable_hour), 32'd0);
    check("rst_tick", 32'(bus.tick_1hz), 32'd0);
    check("rst_leds", {4'h0, bus.led_m2, bus.led_m1, bus.led_s2, bus.led_s1},
          {4'h0, 7'h40, 7'h40, 7'h40, 7'h40});

    // Free run: ticks every 10 cycles, minute carry after 60 s.
    reset = 1'b1; bus.run = 1'b1;
    wait_tick(n);
    check("first_tick_lat", 32'(n), 32'd9);
    check("sec_before_tick", 32'(bus.sec), 32'd0);
    cyc(1);
    check("sec_after_tick", 32'(bus.sec), 32'd1);
    check("tick_strobe_low", 32'(bus.tick_1hz), 32'd0);
    wait_tick(n);
    check("tick_period", 32'(n), 32'd9);
    cyc(581);
    check("wrap_sec", 32'(bus.sec), 32'd0);
    check("wrap_min", 32'(bus.min), 32'd1);
    check("no_eq60_min_carry", 32'(bus.equal60), 32'd0);

    // Held down-press: exactly one decrement, disable_hour while held.
    bus.adj_sel = 1'b0; bus.control0 = 1'b0; bus.control1 = 1'b0;
    cyc(1);
    check("hold_first", 32'(bus.min), 32'd0);
    check("hold_dish", 32'(bus.disable_hour), 32'd1);
    cyc(49);
    check("hold_no_repeat", 32'(bus.min), 32'd0);
    check("hold_dish_late", 32'(bus.disable_hour), 32'd1);
    bus.control1 = 1'b1;
    cyc(1);
    check("release_dish", 32'(bus.disable_hour), 32'd0);

    press(1'b0);
    check("down_0_to_59", 32'(bus.min), 32'd59);
    check("led_m_59", {18'h0, bus.led_m2, bus.led_m1}, {18'h0, 7'h12, 7'h10});
    press(1'b0);
    check("down_59_to_58", 32'(bus.min), 32'd58);
    check("led_m1_8", 32'(bus.led_m1), 32'h00);
    press(1'b1);
    check("up_58_to_59", 32'(bus.min), 32'd59);
    bus.adj_sel = 1'b0; bus.control0 = 1'b1; bus.control1 = 1'b0;
    cnt = 0;
    cyc(1);
    check("up_59_to_0", 32'(bus.min), 32'd0);
    bus.control1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.equal60 !== 1'b0) cnt++;
      cyc(1);
    end
    check("adj_no_eq60", 32'(cnt), 32'd0);
    press(1'b0);
    check("back_to_59", 32'(bus.min), 32'd59);

    // Seconds clear mid-second, then freeze with run=0.
    sync_clear();
    cyc(375);
    check("sec_37", 32'(bus.sec), 32'd37);
    check("led_s_37", {18'h0, bus.led_s2, bus.led_s1}, {18'h0, 7'h30, 7'h78});
    sync_clear();
    check("clr_sec", 32'(bus.sec), 32'd0);
    check("clr_min_kept", 32'(bus.min), 32'd59);
    wait_tick(n);
    check("clr_tick_lat", 32'(n), 32'd9);
    cyc(6);
    bus.run = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (bus.tick_1hz !== 1'b0) cnt++;
    end
    check("frz_no_tick", 32'(cnt), 32'd0);
    check("frz_sec", 32'(bus.sec), 32'd1);
    check("frz_min", 32'(bus.min), 32'd59);
    bus.run = 1'b1;
    wait_tick(n);
    check("frz_resume_lat", 32'(n), 32'd4);
    cyc(1);
    check("frz_resume_sec", 32'(bus.sec), 32'd2);

    // Natural 59:59 -> 00:00 with a 4-cycle equal60 pulse.
    sync_clear();
    cyc(599);
    check("pre_wrap_tick", 32'(bus.tick_1hz), 32'd1);
    check("pre_wrap_time", {20'h0, bus.min, bus.sec}, {20'h0, 6'd59, 6'd59});
    check("pre_wrap_eq60", 32'(bus.equal60), 32'd0);
    cyc(1);
    check("wrap_time", {20'h0, bus.min, bus.sec}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.equal60 === 1'b1) cnt++;
      cyc(1);
    end
    check("eq60_len", 32'(cnt), 32'd4);

    // Up-press on the same cycle as the 59:59 tick: carry dropped.
    press(1'b0);
    check("t4_min59", 32'(bus.min), 32'd59);
    sync_clear();
    cyc(599);
    check("t4_tick", 32'(bus.tick_1hz), 32'd1);
    bus.adj_sel = 1'b0; bus.control0 = 1'b1; bus.control1 = 1'b0;
    cyc(1);
    check("t4_time", {20'h0, bus.min, bus.sec}, 32'd0);
    bus.control1 = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.equal60 !== 1'b0) cnt++;
      cyc(1);
    end
    check("t4_no_eq60", 32'(cnt), 32'd0);

    // Reset in the middle of an equal60 pulse.
    press(1'b0);
    sync_clear();
    cyc(600);
    check("t6_eq60_up", 32'(bus.equal60), 32'd1);
    cyc(1);
    #2 reset = 1'b0;
    #1;
    check("t6_eq60_drop", 32'(bus.equal60), 32'd0);
    check("t6_time", {20'h0, bus.min, bus.sec}, 32'd0);
    check("t6_leds", {4'h0, bus.led_m2, bus.led_m1, bus.led_s2, bus.led_s1},
          {4'h0, 7'h40, 7'h40, 7'h40, 7'h40});
    cyc(2);
    reset = 1'b1;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
